sampler_dma_regfile: RTL and testbench
======================================

# sampler_dma_regfile

Parametrised second-generation register file for the sampler DMA unit. It sits between the AXI-Lite slave controller and the per-voice DMA engines. It holds per-voice base address, length and loop mode, and issues single-cycle start/stop pulses. It tracks per-voice busy/done/error status and aggregates done events into a maskable interrupt.

## Interface
Parameters:
- MAX_VOICES, 4, number of DMA voices (1..64)
- NUM_CTRL_REGS, 16, global control/misc words at addresses 0..NUM_CTRL_REGS-1
- ADDR_WIDTH, 10, word-address width of reg_addr_wr/reg_addr_rd
- VERSION, 32'h0002_0000, value returned at address 0

Ports:
- axi_clk  in  1  single clock for all logic
- axi_reset  in  1  asynchronous, active-high reset
- data_in  in  32  write data
- byte_enable  in  4  write byte lanes
- reg_addr_wr  in  ADDR_WIDTH  write word address
- data_wren  in  1  write strobe, one write per cycle
- reg_addr_rd  in  ADDR_WIDTH  read word address
- data_rden  in  1  read strobe
- data_out  out  32  registered read data
- data_out_valid  out  1  high one cycle after data_rden
- dma_base_addr  out  [MAX_VOICES][32]  per-voice base address
- dma_length  out  [MAX_VOICES][32]  per-voice transfer length in bytes
- dma_loop  out  MAX_VOICES  per-voice loop mode
- dma_start  out  MAX_VOICES  one-cycle start pulse
- dma_stop  out  MAX_VOICES  one-cycle stop pulse
- dma_busy  in  MAX_VOICES  engine busy level
- dma_done_evt  in  MAX_VOICES  one-cycle completion pulse from engine
- irq  out  1  level interrupt

## Operation
- Global map: 0 VERSION (RO), 1 MAX_VOICES (RO), 2 VOICE_BASE = NUM_CTRL_REGS (RO), 3 IRQ_PENDING (W1C), 4 IRQ_ENABLE (RW), 5 BUSY (RO, mirrors dma_busy). Any other global address reads 32'hBEEFDEAD, and writes to it are ignored.
- Voice v occupies 4 words at VOICE_BASE + 4v:
  - +0 BASE_ADDR (RW)
  - +1 LENGTH (RW)
  - +2 CONTROL: bit0 START W1 pulse, bit1 STOP W1 pulse, bit2 LOOP RW. Reads return {29'b0, LOOP, 2'b0}.
  - +3 STATUS (RO): bit0 busy (dma_busy[v]), bit1 DONE sticky, bit2 START_ERR sticky.
- Addresses at or above VOICE_BASE + 4*MAX_VOICES read 32'hBEEFDEAD, and writes to them are ignored.
- byte_enable masks every RW and W1C register per lane. START, STOP and LOOP use lane 0 only.
- START write:
  - With dma_busy[v]=0, dma_start[v] pulses for exactly one cycle and DONE[v] clears.
  - With dma_busy[v]=1, no pulse is issued and START_ERR[v] sets.
- START_ERR clears only on a START write accepted while idle.
- START and STOP in the same write: STOP wins and dma_start stays low.
- dma_done_evt[v] sets DONE[v] and IRQ_PENDING[v].
- If a W1C of IRQ_PENDING[v] and dma_done_evt[v] occur in the same cycle, the set wins.
- irq = |(IRQ_PENDING & IRQ_ENABLE), registered.
- Writes to RO registers are ignored.

## Timing
- Reset (asynchronous assert, synchronous release): all outputs 0, all registers 0, data_out 0, data_out_valid 0.
- Write with data_wren at cycle N:
  - Register updated at edge N+1.
  - dma_start/dma_stop high during cycle N+1 only.
- Read with data_rden at cycle N: data_out and data_out_valid valid in cycle N+1. data_out holds its value when data_rden is low.
- Read-after-write to the same address in consecutive cycles returns the new value.
- irq follows a pending/enable change by one cycle.
- dma_done_evt at cycle N is visible in STATUS and IRQ_PENDING reads issued at cycle N+1 or later.
- Reset asserted mid-pulse truncates the pulse immediately.

## Configuration
- SAMPLER_DMA_IRQ_EN defined: IRQ_PENDING, IRQ_ENABLE and the irq output are implemented as described.
- SAMPLER_DMA_IRQ_EN not defined:
  - irq tied to 0.
  - Addresses 3 and 4 read 32'hBEEFDEAD, and writes to them are ignored.
  - DONE status is still tracked.

## Structure
- Package sampler_dma_pkg holds:
  - REGS_PER_VOICE = 4.
  - Global address constants (ADDR_VERSION .. ADDR_BUSY).
  - Voice word offsets (OFF_BASE, OFF_LEN, OFF_CTRL, OFF_STAT).
  - CONTROL/STATUS bit indices.
  - DEFAULT_READ = 32'hBEEFDEAD.
  - Function clogb2.
- Sub-module sampler_dma_voice_regs is instantiated MAX_VOICES times via generate. It owns BASE_ADDR, LENGTH, LOOP, DONE, START_ERR and start/stop pulse generation.
- The top level owns address decode, global registers, the IRQ logic and the read mux.

## Test plan
- Reset: assert axi_reset mid-operation → all outputs 0. Read address 0 → 32'h0002_0000; address 1 → 4; address 2 → 16.
- Write 32'hA000_0000 to voice 2 BASE_ADDR (addr 24), byte_enable 4'b0011, over a prior value of 32'h1234_5678 → reads back 32'h1234_0000.
- Write 32'h1 to voice 1 CONTROL (addr 22) with dma_busy=0 → dma_start[1] high for exactly one cycle. Repeat with dma_busy[1]=1 → no pulse, STATUS[1] reads 32'h5.
- Write 32'h3 to voice 0 CONTROL → dma_stop[0] pulses, dma_start[0] stays low.
- With IRQ_ENABLE=4'b1111: pulse dma_done_evt[3] → irq=1 next cycle, IRQ_PENDING reads 32'h8. W1C of 32'h8 in the same cycle as a new done_evt[3] → pending stays 32'h8.
- Read address 16+4*MAX_VOICES (32) and address 7 → 32'hBEEFDEAD with data_out_valid one cycle after data_rden. Build without SAMPLER_DMA_IRQ_EN → irq stays 0 and address 3 reads 32'hBEEFDEAD.

Source files
------------

// File: rtl/sampler_dma_pkg.sv
// Shared constants and helpers for the sampler DMA register file: address map,
// voice word offsets, CONTROL/STATUS bit positions and byte-lane merging.
package sampler_dma_pkg;

  localparam int REGS_PER_VOICE = 4;

  localparam logic [31:0] ADDR_VERSION     = 32'd0;
  localparam logic [31:0] ADDR_NUM_VOICES  = 32'd1;
  localparam logic [31:0] ADDR_VOICE_BASE  = 32'd2;
  localparam logic [31:0] ADDR_IRQ_PENDING = 32'd3;
  localparam logic [31:0] ADDR_IRQ_ENABLE  = 32'd4;
  localparam logic [31:0] ADDR_BUSY        = 32'd5;

  typedef enum logic [1:0] {
    OFF_BASE = 2'd0,
    OFF_LEN  = 2'd1,
    OFF_CTRL = 2'd2,
    OFF_STAT = 2'd3
  } voice_off_e;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_LOOP  = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  localparam logic [31:0] DEFAULT_READ = 32'hBEEF_DEAD;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    return (old_val & ~byte_mask(be)) | (new_val & byte_mask(be));
  endfunction

endpackage

// File: rtl/sampler_dma_voice_regs.sv
// Per-voice register slice: BASE_ADDR, LENGTH, LOOP, sticky DONE/START_ERR
// and the single-cycle start/stop pulses towards one DMA engine.
module sampler_dma_voice_regs
  import sampler_dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_base,
  input  logic        wr_len,
  input  logic        wr_ctrl,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  input  logic        busy,
  input  logic        done_evt,
  output logic [31:0] base_addr,
  output logic [31:0] length,
  output logic        loop,
  output logic        done,
  output logic        start_err,
  output logic        start,
  output logic        stop
);

  logic ctrl_lane0;
  logic start_req;
  logic stop_req;

  assign ctrl_lane0 = wr_ctrl && be[0];
  assign start_req  = ctrl_lane0 && wdata[CTRL_START];
  assign stop_req   = ctrl_lane0 && wdata[CTRL_STOP];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_addr <= '0;
      length    <= '0;
      loop      <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
      start     <= 1'b0;
      stop      <= 1'b0;
    end else begin
      start <= 1'b0;
      stop  <= stop_req;
      if (wr_base)    base_addr <= merge_bytes(base_addr, wdata, be);
      if (wr_len)     length    <= merge_bytes(length, wdata, be);
      if (ctrl_lane0) loop      <= wdata[CTRL_LOOP];
      // A simultaneous STOP suppresses the start request entirely.
      if (start_req && !stop_req) begin
        if (busy) begin
          start_err <= 1'b1;
        end else begin
          start     <= 1'b1;
          start_err <= 1'b0;
          done      <= 1'b0;
        end
      end
      if (done_evt) done <= 1'b1;
    end
  end

endmodule

// File: rtl/sampler_dma_regfile.sv
// Sampler DMA register file top: address decode, global registers, IRQ and read mux.
// Optional build macro SAMPLER_DMA_IRQ_EN enables IRQ_PENDING/IRQ_ENABLE and irq.
module sampler_dma_regfile
  import sampler_dma_pkg::*;
#(
  parameter int          MAX_VOICES    = 4,
  parameter int          NUM_CTRL_REGS = 16,
  parameter int          ADDR_WIDTH    = 10,
  parameter logic [31:0] VERSION       = 32'h0002_0000
) (
  input  logic                        axi_clk,
  input  logic                        axi_reset,
  input  logic [31:0]                 data_in,
  input  logic [3:0]                  byte_enable,
  input  logic [ADDR_WIDTH-1:0]       reg_addr_wr,
  input  logic                        data_wren,
  input  logic [ADDR_WIDTH-1:0]       reg_addr_rd,
  input  logic                        data_rden,
  output logic [31:0]                 data_out,
  output logic                        data_out_valid,
  output logic [MAX_VOICES-1:0][31:0] dma_base_addr,
  output logic [MAX_VOICES-1:0][31:0] dma_length,
  output logic [MAX_VOICES-1:0]       dma_loop,
  output logic [MAX_VOICES-1:0]       dma_start,
  output logic [MAX_VOICES-1:0]       dma_stop,
  input  logic [MAX_VOICES-1:0]       dma_busy,
  input  logic [MAX_VOICES-1:0]       dma_done_evt,
  output logic                        irq
);

  // Global 32-bit words can only expose the first 32 voices.
  localparam int          LO_W       = (MAX_VOICES > 32) ? 32 : MAX_VOICES;
  localparam logic [31:0] VOICE_SPAN = 32'(REGS_PER_VOICE * MAX_VOICES);

  logic [31:0]           wr_rel;
  logic [31:0]           rd_rel;
  logic                  wr_voice;
  logic [MAX_VOICES-1:0] v_done;
  logic [MAX_VOICES-1:0] v_err;
  logic [31:0]           rd_data;

  // Below-range addresses wrap to huge offsets, so one compare bounds both ends.
  assign wr_rel   = 32'(reg_addr_wr) - 32'(NUM_CTRL_REGS);
  assign rd_rel   = 32'(reg_addr_rd) - 32'(NUM_CTRL_REGS);
  assign wr_voice = data_wren && (wr_rel < VOICE_SPAN);

  for (genvar v = 0; v < MAX_VOICES; v++) begin : g_voice
    logic hit;
    assign hit = wr_voice && (wr_rel[31:2] == 30'(v));

    sampler_dma_voice_regs u_voice (
      .clk       (axi_clk),
      .rst       (axi_reset),
      .wr_base   (hit && (wr_rel[1:0] == OFF_BASE)),
      .wr_len    (hit && (wr_rel[1:0] == OFF_LEN)),
      .wr_ctrl   (hit && (wr_rel[1:0] == OFF_CTRL)),
      .wdata     (data_in),
      .be        (byte_enable),
      .busy      (dma_busy[v]),
      .done_evt  (dma_done_evt[v]),
      .base_addr (dma_base_addr[v]),
      .length    (dma_length[v]),
      .loop      (dma_loop[v]),
      .done      (v_done[v]),
      .start_err (v_err[v]),
      .start     (dma_start[v]),
      .stop      (dma_stop[v])
    );
  end

`ifdef SAMPLER_DMA_IRQ_EN
  logic [LO_W-1:0] irq_pending;
  logic [LO_W-1:0] irq_enable;
  logic [LO_W-1:0] pend_clr;
  logic [31:0]     wr_mask;
  logic            wr_pend;
  logic            wr_en;

  assign wr_mask  = byte_mask(byte_enable);
  assign wr_pend  = data_wren && (32'(reg_addr_wr) == ADDR_IRQ_PENDING);
  assign wr_en    = data_wren && (32'(reg_addr_wr) == ADDR_IRQ_ENABLE);
  assign pend_clr = wr_pend ? (data_in[LO_W-1:0] & wr_mask[LO_W-1:0]) : '0;

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      irq_pending <= '0;
      irq_enable  <= '0;
      irq         <= 1'b0;
    end else begin
      // A done event in the same cycle as its W1C keeps the bit set.
      irq_pending <= (irq_pending & ~pend_clr) | dma_done_evt[LO_W-1:0];
      if (wr_en)
        irq_enable <= (irq_enable & ~wr_mask[LO_W-1:0]) | (data_in[LO_W-1:0] & wr_mask[LO_W-1:0]);
      irq <= |(irq_pending & irq_enable);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // NOTE: rd_data gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_data = DEFAULT_READ;
    if (rd_rel < VOICE_SPAN) begin
      for (int v = 0; v < MAX_VOICES; v++) begin
        if (rd_rel[31:2] == 30'(v)) begin
          case (rd_rel[1:0])
            OFF_BASE: rd_data = dma_base_addr[v];
            OFF_LEN:  rd_data = dma_length[v];
            OFF_CTRL: begin
              rd_data            = '0;
              rd_data[CTRL_LOOP] = dma_loop[v];
            end
            default: begin
              rd_data            = '0;
              rd_data[STAT_BUSY] = dma_busy[v];
              rd_data[STAT_DONE] = v_done[v];
              rd_data[STAT_ERR]  = v_err[v];
            end
          endcase
        end
      end
    end else begin
      case (32'(reg_addr_rd))
        ADDR_VERSION:     rd_data = VERSION;
        ADDR_NUM_VOICES:  rd_data = 32'(MAX_VOICES);
        ADDR_VOICE_BASE:  rd_data = 32'(NUM_CTRL_REGS);
`ifdef SAMPLER_DMA_IRQ_EN
        ADDR_IRQ_PENDING: rd_data = 32'(irq_pending);
        ADDR_IRQ_ENABLE:  rd_data = 32'(irq_enable);
`endif
        ADDR_BUSY:        rd_data = 32'(dma_busy[LO_W-1:0]);
        default:          rd_data = DEFAULT_READ;
      endcase
    end
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= data_rden;
      if (data_rden) data_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_sampler_dma_regfile.sv
// Directed self-checking bench for sampler_dma_regfile (default parameters).
// IRQ scenarios follow the SAMPLER_DMA_IRQ_EN build macro.
module tb_sampler_dma_regfile;

  logic              axi_clk;
  logic              axi_reset;
  logic [31:0]       data_in;
  logic [3:0]        byte_enable;
  logic [9:0]        reg_addr_wr;
  logic              data_wren;
  logic [9:0]        reg_addr_rd;
  logic              data_rden;
  logic [31:0]       data_out;
  logic              data_out_valid;
  logic [3:0][31:0]  dma_base_addr;
  logic [3:0][31:0]  dma_length;
  logic [3:0]        dma_loop;
  logic [3:0]        dma_start;
  logic [3:0]        dma_stop;
  logic [3:0]        dma_busy;
  logic [3:0]        dma_done_evt;
  logic              irq;

  int n_cmp = 0;
  int n_bad = 0;

  sampler_dma_regfile dut (
    .axi_clk        (axi_clk),
    .axi_reset      (axi_reset),
    .data_in        (data_in),
    .byte_enable    (byte_enable),
    .reg_addr_wr    (reg_addr_wr),
    .data_wren      (data_wren),
    .reg_addr_rd    (reg_addr_rd),
    .data_rden      (data_rden),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .dma_base_addr  (dma_base_addr),
    .dma_length     (dma_length),
    .dma_loop       (dma_loop),
    .dma_start      (dma_start),
    .dma_stop       (dma_stop),
    .dma_busy       (dma_busy),
    .dma_done_evt   (dma_done_evt),
    .irq            (irq)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    reg_addr_wr = a;
    data_in     = d;
    byte_enable = be;
    data_wren   = 1'b1;
    tick();
    data_wren   = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] d, output logic v);
    reg_addr_rd = a;
    data_rden   = 1'b1;
    tick();
    data_rden   = 1'b0;
    d = data_out;
    v = data_out_valid;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    rd(10'd0, d, v);
    wr(10'd16, 32'hDEAD_0001, 4'hF);
    wr(10'd18, 32'h0000_0005, 4'hF);  // start voice 0, loop on
    if (dma_start !== 4'b0001) begin n_bad++; $display("FAIL pre_reset_start: got %b want %b", dma_start, 4'b0001); end
    n_cmp++;
    #2 axi_reset = 1'b1;
    #1;
    if (dma_start !== 4'b0000) begin n_bad++; $display("FAIL reset_start_truncated: got %b want 0000", dma_start); end
    n_cmp++;
    if (dma_base_addr !== 128'd0 || dma_loop !== 4'b0 || dma_stop !== 4'b0) begin
      n_bad++; $display("FAIL reset_voice_outputs: base %h loop %b stop %b want all 0", dma_base_addr, dma_loop, dma_stop);
    end
    n_cmp++;
    if (data_out !== 32'd0 || data_out_valid !== 1'b0 || irq !== 1'b0) begin
      n_bad++; $display("FAIL reset_read_irq: data_out %h valid %b irq %b want 0", data_out, data_out_valid, irq);
    end
    n_cmp++;
    tick();
    tick();
    #3 axi_reset = 1'b0;
    tick();
    rd(10'd0, d, v);
    if (d !== 32'h0002_0000 || v !== 1'b1) begin n_bad++; $display("FAIL version: got %h/%b want 00020000/1", d, v); end
    n_cmp++;
    rd(10'd1, d, v);
    if (d !== 32'd4) begin n_bad++; $display("FAIL num_voices: got %h want 4", d); end
    n_cmp++;
    rd(10'd2, d, v);
    if (d !== 32'd16) begin n_bad++; $display("FAIL voice_base: got %h want 16", d); end
    n_cmp++;
    rd(10'd16, d, v);
    if (d !== 32'd0) begin n_bad++; $display("FAIL base_after_reset: got %h want 0", d); end
    n_cmp++;
  endtask

  task automatic test_byte_enable();
    logic [31:0] d;
    logic v;
    wr(10'd24, 32'h1234_5678, 4'hF);
    wr(10'd24, 32'hA000_0000, 4'b0011);
    rd(10'd24, d, v);
    if (d !== 32'h1234_0000) begin n_bad++; $display("FAIL byte_enable_read: got %h want 12340000", d); end
    n_cmp++;
    if (dma_base_addr[2] !== 32'h1234_0000) begin n_bad++; $display("FAIL byte_enable_port: got %h want 12340000", dma_base_addr[2]); end
    n_cmp++;
    wr(10'd17, 32'h0000_55AA, 4'hF);
    rd(10'd17, d, v);
    if (d !== 32'h0000_55AA || dma_length[0] !== 32'h0000_55AA) begin
      n_bad++; $display("FAIL raw_length: got %h port %h want 000055aa", d, dma_length[0]);
    end
    n_cmp++;
  endtask

  task automatic test_start();
    logic [31:0] d;
    logic v;
    dma_busy = 4'b0000;
    wr(10'd22, 32'h1, 4'hF);
    if (dma_start !== 4'b0010) begin n_bad++; $display("FAIL start_pulse: got %b want 0010", dma_start); end
    n_cmp++;
    tick();
    if (dma_start !== 4'b0000) begin n_bad++; $display("FAIL start_one_cycle: got %b want 0000", dma_start); end
    n_cmp++;
    wr(10'd22, 32'h1, 4'b1110);
    if (dma_start !== 4'b0000) begin n_bad++; $display("FAIL start_lane0_only: got %b want 0000", dma_start); end
    n_cmp++;
    dma_busy = 4'b0010;
    wr(10'd22, 32'h1, 4'hF);
    if (dma_start !== 4'b0000) begin n_bad++; $display("FAIL start_while_busy: got %b want 0000", dma_start); end
    n_cmp++;
    rd(10'd23, d, v);
    if (d !== 32'h5) begin n_bad++; $display("FAIL status_start_err: got %h want 5", d); end
    n_cmp++;
    dma_busy = 4'b0000;
    wr(10'd22, 32'h1, 4'hF);
    rd(10'd23, d, v);
    if (d !== 32'h0) begin n_bad++; $display("FAIL start_err_cleared: got %h want 0", d); end
    n_cmp++;
  endtask

  task automatic test_stop_loop();
    logic [31:0] d;
    logic v;
    wr(10'd18, 32'h3, 4'hF);
    if (dma_stop !== 4'b0001 || dma_start !== 4'b0000) begin
      n_bad++; $display("FAIL stop_wins: stop %b start %b want 0001/0000", dma_stop, dma_start);
    end
    n_cmp++;
    tick();
    if (dma_stop !== 4'b0000) begin n_bad++; $display("FAIL stop_one_cycle: got %b want 0000", dma_stop); end
    n_cmp++;
    wr(10'd18, 32'hFFFF_FFFC, 4'hF);
    rd(10'd18, d, v);
    if (d !== 32'h4 || dma_loop !== 4'b0001) begin n_bad++; $display("FAIL loop_rw: got %h loop %b want 4/0001", d, dma_loop); end
    n_cmp++;
  endtask

  task automatic test_done();
    logic [31:0] d;
    logic v;
    dma_done_evt = 4'b0100;
    tick();
    dma_done_evt = 4'b0000;
    rd(10'd27, d, v);
    if (d !== 32'h2) begin n_bad++; $display("FAIL done_sticky: got %h want 2", d); end
    n_cmp++;
    wr(10'd26, 32'h1, 4'hF);
    rd(10'd27, d, v);
    if (d !== 32'h0) begin n_bad++; $display("FAIL done_cleared_by_start: got %h want 0", d); end
    n_cmp++;
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic v;
`ifdef SAMPLER_DMA_IRQ_EN
    wr(10'd3, 32'hFFFF_FFFF, 4'hF);
    wr(10'd4, 32'h0000_000F, 4'hF);
    tick();
    if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_idle: got %b want 0", irq); end
    n_cmp++;
    dma_done_evt = 4'b1000;
    tick();
    dma_done_evt = 4'b0000;
    tick();
    if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_raised: got %b want 1", irq); end
    n_cmp++;
    rd(10'd3, d, v);
    if (d !== 32'h8) begin n_bad++; $display("FAIL irq_pending: got %h want 8", d); end
    n_cmp++;
    dma_done_evt = 4'b1000;
    wr(10'd3, 32'h8, 4'hF);
    dma_done_evt = 4'b0000;
    rd(10'd3, d, v);
    if (d !== 32'h8) begin n_bad++; $display("FAIL set_beats_w1c: got %h want 8", d); end
    n_cmp++;
    wr(10'd3, 32'h8, 4'hF);
    rd(10'd3, d, v);
    if (d !== 32'h0) begin n_bad++; $display("FAIL w1c_clear: got %h want 0", d); end
    n_cmp++;
    tick();
    if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_dropped: got %b want 0", irq); end
    n_cmp++;
`else
    wr(10'd4, 32'h0000_000F, 4'hF);
    dma_done_evt = 4'b1000;
    tick();
    dma_done_evt = 4'b0000;
    tick();
    tick();
    if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_tied_low: got %b want 0", irq); end
    n_cmp++;
    rd(10'd3, d, v);
    if (d !== 32'hBEEF_DEAD) begin n_bad++; $display("FAIL pending_unmapped: got %h want beefdead", d); end
    n_cmp++;
    rd(10'd4, d, v);
    if (d !== 32'hBEEF_DEAD) begin n_bad++; $display("FAIL enable_unmapped: got %h want beefdead", d); end
    n_cmp++;
    rd(10'd31, d, v);
    if (d !== 32'h2) begin n_bad++; $display("FAIL done_without_irq: got %h want 2", d); end
    n_cmp++;
`endif
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic v;
    rd(10'd32, d, v);
    if (d !== 32'hBEEF_DEAD || v !== 1'b1) begin n_bad++; $display("FAIL above_voices: got %h/%b want beefdead/1", d, v); end
    n_cmp++;
    tick();
    if (data_out_valid !== 1'b0 || data_out !== 32'hBEEF_DEAD) begin
      n_bad++; $display("FAIL read_hold: got %h/%b want beefdead/0", data_out, data_out_valid);
    end
    n_cmp++;
    wr(10'd7, 32'h1234_5678, 4'hF);
    wr(10'd32, 32'h1234_5678, 4'hF);
    rd(10'd7, d, v);
    if (d !== 32'hBEEF_DEAD || v !== 1'b1) begin n_bad++; $display("FAIL global_gap: got %h/%b want beefdead/1", d, v); end
    n_cmp++;
    wr(10'd0, 32'h0, 4'hF);
    rd(10'd0, d, v);
    if (d !== 32'h0002_0000) begin n_bad++; $display("FAIL version_ro: got %h want 00020000", d); end
    n_cmp++;
    dma_busy = 4'b1010;
    rd(10'd5, d, v);
    if (d !== 32'hA) begin n_bad++; $display("FAIL busy_mirror: got %h want a", d); end
    n_cmp++;
    dma_busy = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axi_reset    = 1'b1;
    data_in      = '0;
    byte_enable  = '0;
    reg_addr_wr  = '0;
    data_wren    = 1'b0;
    reg_addr_rd  = '0;
    data_rden    = 1'b0;
    dma_busy     = '0;
    dma_done_evt = '0;
    tick();
    tick();
    #3 axi_reset = 1'b0;
    tick();
    test_reset();
    test_byte_enable();
    test_start();
    test_stop_loop();
    test_done();
    test_irq();
    test_unmapped();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
